mux_4to1_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4:1 16-bit mux path among four valid/ready requesters.
//  - Picks one requester per accepted beat.
//  - Drives the mux select and routes the winner's data into a registered output stage.
//  - Sits between four producer ports and a single downstream consumer.
//  - Optional packet lock keeps a grant for a whole multi-beat packet.

---
 rtl/mux_4to1_rr_arbiter_if.sv | 45 ++++
 rtl/mux_4to1_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux_4to1_rr_arbiter_if.sv
// Bus bundle between four valid/ready producers, the round-robin arbiter and
// a single downstream consumer. in_last exists only when MUX_ARB_PKT_LOCK_EN
// is defined (packet lock build).
interface mux_arb_if #(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2
);
  logic [3:0]           in_valid;
  logic [WIDTH-1:0]     in_data0;
  logic [WIDTH-1:0]     in_data1;
  logic [WIDTH-1:0]     in_data2;
  logic [WIDTH-1:0]     in_data3;
  logic [3:0]           in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;
  logic                 out_ready;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [3:0]           in_last;

  // Producers and consumer side (testbench / surrounding logic)
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready, in_last,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready, in_last,
    output in_ready, out_valid, out_data, out_sel
  );
`else
  // Producers and consumer side (testbench / surrounding logic)
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing one AND-OR 4:1 mux path among four valid/ready
// requesters, feeding a single registered output stage.
// Optional feature macro: MUX_ARB_PKT_LOCK_EN -- holds the grant on one
// requester until it presents in_last on an accepted beat.
module mux_4to1_rr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  mux_arb_if.slave  bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [SEL_WIDTH-1:0] lock_id_q, lock_id_d;
  logic                 acc_last;
`endif

  logic                 load;
  logic [3:0]           rr_gnt;
  logic [3:0]           in_ready_c;
  logic [3:0]           acc_gnt;
  logic                 accept;
  logic [SEL_WIDTH-1:0] acc_idx;
  logic [WIDTH-1:0]     mux_data;

  // Output register can take a new beat when empty or being drained this cycle
  assign load = !out_valid_q || bus.out_ready;

  // Rotating search for the first valid requester starting at rr_ptr
  always_comb begin
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    rr_gnt = 4'b0000;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + SEL_WIDTH'(k);
      if (!found && bus.in_valid[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: enter LOCK on a non-last accepted beat, leave on the last one
  always_comb begin
    state_d = state_q;
`ifdef MUX_ARB_PKT_LOCK_EN
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: if (accept && !acc_last) begin
        state_d   = LOCK;
        lock_id_d = acc_idx;
      end
      LOCK: if (accept && acc_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`else
    state_d = IDLE;
`endif
  end

  // FSM output: one-hot in_ready, forced low in reset and while stalled
  always_comb begin
    in_ready_c = 4'b0000;
    if (!rst && load) begin
      case (state_q)
        IDLE:    in_ready_c = rr_gnt;
`ifdef MUX_ARB_PKT_LOCK_EN
        LOCK:    in_ready_c = 4'b0001 << lock_id_q;
`endif
        default: in_ready_c = 4'b0000;
      endcase
    end
  end

  assign bus.in_ready = in_ready_c;
  assign acc_gnt      = bus.in_valid & in_ready_c;
  assign accept       = |acc_gnt;
  assign acc_idx      = {acc_gnt[2] | acc_gnt[3], acc_gnt[1] | acc_gnt[3]};
`ifdef MUX_ARB_PKT_LOCK_EN
  assign acc_last     = |(acc_gnt & bus.in_last);
`endif

  // Grant-qualified AND-OR mux: no priority between inputs
  assign mux_data = ({WIDTH{acc_gnt[0]}} & bus.in_data0) |
                    ({WIDTH{acc_gnt[1]}} & bus.in_data1) |
                    ({WIDTH{acc_gnt[2]}} & bus.in_data2) |
                    ({WIDTH{acc_gnt[3]}} & bus.in_data3);

  // Output stage and pointer next-state: capture on accept, empty on idle load
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = mux_data;
        out_sel_d  = acc_idx;
        rr_ptr_d   = acc_idx + SEL_WIDTH'(1);
      end
    end
  end

  // Output stage and pointer registers; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef MUX_ARB_PKT_LOCK_EN
      lock_id_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_ARB_PKT_LOCK_EN
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Directed bench for mux_4to1_rr_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked after that, well before the next edge.
module tb_mux_4to1_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mux_arb_if #(.WIDTH(16), .SEL_WIDTH(2)) bus ();

  mux_4to1_rr_arbiter #(.WIDTH(16), .SEL_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [15:0] d);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".sel"},   32'(bus.out_sel),   32'(s));
    chk({tag, ".data"},  32'(bus.out_data),  32'(d));
  endtask

  initial begin
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;

    // Reset with every requester valid
    rst = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data0  = 16'h1111;
    bus.in_data1  = 16'h2222;
    bus.in_data2  = 16'h3333;
    bus.in_data3  = 16'h4444;
    bus.out_ready = 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
    bus.in_last   = 4'hF;
`endif
    tick();
    tick();
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
    chk_out("rst", 1'b0, 2'd0, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rel.first_grant", 32'(bus.in_ready), 32'h1);

    // All four valid: rotation 0,1,2,3,0 with no bubbles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rot%0d", i), 1'b1, 2'(i % 4), exp_d[i % 4]);
    end
    // rr_ptr now 1

    // Single requester 2 with downstream stall
    bus.in_valid = 4'b0100;
    bus.in_data2 = 16'hBEEF;
    #1;
    chk("stall.pre_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk_out("stall.cap", 1'b1, 2'd2, 16'hBEEF);
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 2'd2, 16'hBEEF);
    end
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    chk_out("stall.drain_once", 1'b0, 2'd2, 16'hBEEF);
    // rr_ptr now 3

    // Sparse traffic: req 3, idle, then req 0 and req 3 together
    bus.in_valid = 4'b1000;
    #1;
    chk("sparse.r3_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk_out("sparse.r3", 1'b1, 2'd3, 16'h4444);
    bus.in_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle%0d.valid", i), 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 4'b1001;
    #1;
    chk("sparse.wrap_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("sparse.r0", 1'b1, 2'd0, 16'h1111);

    // Reset pulsed during a stall
    bus.in_valid  = 4'b0100;
    bus.in_data2  = 16'h3333;
    bus.out_ready = 1'b0;
    tick();
    chk_out("rstmid.hold", 1'b1, 2'd0, 16'h1111);
    rst = 1'b1;
    #1;
    chk("rstmid.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("rstmid.cleared", 1'b0, 2'd0, 16'h0000);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0000;
    tick();
    chk("rstmid.no_ghost", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 4'hF;
    #1;
    chk("rstmid.ptr_reset", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 4'b0000;

`ifdef MUX_ARB_PKT_LOCK_EN
    // Packet lock: move pointer to 1 with a single-beat packet from req 0
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'hF;
    tick();
    chk_out("lock.pre", 1'b1, 2'd0, 16'h1111);
    bus.in_valid = 4'b0111;
    bus.in_last  = 4'b1101;
    #1;
    chk("lock.b0_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk_out("lock.b0", 1'b1, 2'd1, 16'h2222);
    chk("lock.held_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk_out("lock.b1", 1'b1, 2'd1, 16'h2222);
    bus.in_last = 4'hF;
    tick();
    chk_out("lock.b2", 1'b1, 2'd1, 16'h2222);
    bus.in_valid = 4'b0101;
    #1;
    chk("lock.release_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk_out("lock.after2", 1'b1, 2'd2, 16'h3333);
    bus.in_valid = 4'b0001;
    tick();
    chk_out("lock.after0", 1'b1, 2'd0, 16'h1111);
    bus.in_valid = 4'b0000;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
